coord_sequencer: RTL and testbench
==================================

COORD_SEQUENCER -- requirements
Module: coord_sequencer

Interface
REQ-001 Parameter DWELL, default 4, meaning: cycles each column/row selection is held; legal 1..255, value 0 behaves as 1.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 mode_a  input  1  mode switch A; mode 1 (manual coordinate) = mode_a & ~mode_b.
REQ-005 mode_b  input  1  mode switch B; mode 2 (auto scan) = ~mode_a & mode_b; 00 and 11 are invalid.
REQ-006 col_sel  input  3  requested column, one-hot, bit0..bit2 = C,D,E.
REQ-007 row_sel  input  3  requested row, one-hot, bit0..bit2 = F,G,H.
REQ-008 start  input  1  single-cycle request to begin a sequence.
REQ-009 col_out  output  3  one-hot column drive, 000 when inactive.
REQ-010 row_out  output  3  one-hot row drive, 000 when inactive.
REQ-011 pos_idx  output  4  current position index 0..8 (col*3+row), 0 when idle.
REQ-012 busy  output  1  high while a sequence is in progress.
REQ-013 done  output  1  one-cycle pulse at sequence completion.
REQ-014 abort  output  1  one-cycle pulse when a sequence is cancelled.
REQ-015 err  output  1  sticky flag for a rejected start.

Function
REQ-016 States SHALL be IDLE, COL, ROW, DONE; state register, counters and outputs all registered.
REQ-017 In IDLE, start SHALL be sampled; mode and selections are latched on the same edge.
REQ-018 Manual start accepted only if col_sel and row_sel are each exactly one-hot; otherwise stay IDLE, err=1.
REQ-019 Start with invalid mode (00/11) SHALL be rejected: stay IDLE, err=1.
REQ-020 Accepted start SHALL clear err and enter COL; busy=1 from the following cycle.
REQ-021 COL: col_out = current column, row_out=000, held exactly DWELL cycles.
REQ-022 ROW: col_out held, row_out = current row, held exactly DWELL cycles.
REQ-023 Manual: after ROW go to DONE; total start-to-done = 1+2*DWELL cycles.
REQ-024 Auto: positions 0..8 in order, column outer (C,D,E), row inner (F,G,H); COL then ROW for each position; after position 8 ROW go to DONE; start-to-done = 1+18*DWELL cycles.
REQ-025 Auto: col_sel/row_sel SHALL be ignored.
REQ-026 DONE lasts one cycle: done=1, busy=0, col_out=row_out=000, pos_idx=0, then IDLE.
REQ-027 start while busy or in DONE SHALL be ignored, no err change.
REQ-028 Mode inputs differing from the latched mode while in COL/ROW: next cycle IDLE, abort=1 one cycle, busy=0, outputs 000, no done.
REQ-029 Mode change and final dwell cycle on the same edge: abort wins, no done.
REQ-030 Dwell counter SHALL be 8 bits, reload on each COL/ROW entry, never wrap mid-dwell.
REQ-031 pos_idx SHALL equal the latched manual position in manual mode and the scan position in auto mode while busy.

Reset
REQ-032 rst asserted SHALL immediately force IDLE, col_out=000, row_out=000, pos_idx=0, busy=0, done=0, abort=0, err=0, counters 0.
REQ-033 rst mid-sequence SHALL cancel without abort or done pulse; first start is sampled on the first edge after deassertion.

Verification (DWELL=4)
REQ-034 mode 10, col=010, row=100, start -> busy next cycle, col_out=010 4 cycles, then row_out=100 with col_out=010 4 cycles, done at cycle 9, pos_idx=5.
REQ-035 mode 01, start -> 9 positions, col_out C,C,C,D,D,D,E,E,E, row_out F,G,H repeating, done at cycle 73.
REQ-036 mode 10, col=011, start -> no busy, err=1; then valid start -> err=0, sequence runs.
REQ-037 mode 11 start -> err=1, outputs 000; start during busy -> ignored, timing unchanged.
REQ-038 auto run, mode_b dropped at position 3 -> abort=1 one cycle, outputs 000, no done.
REQ-039 rst asserted asynchronously mid ROW -> outputs 000 before next clock edge, no abort/done.

Source files
------------

// File: rtl/coord_sequencer.sv
// Column/row drive sequencer: manual single-coordinate or automatic 3x3 scan,
// each column and row selection held for DWELL clock cycles.
module coord_sequencer #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_a,
    input  logic       mode_b,
    input  logic [2:0] col_sel,
    input  logic [2:0] row_sel,
    input  logic       start,
    output logic [2:0] col_out,
    output logic [2:0] row_out,
    output logic [3:0] pos_idx,
    output logic       busy,
    output logic       done,
    output logic       abort,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COL,
        S_ROW,
        S_DONE
    } state_t;

    // A dwell of 0 is treated as 1; the counter is loaded with dwell-1.
    localparam logic [7:0] LP_DW  = (DWELL == 0) ? 8'd1 : 8'(DWELL);
    localparam logic [7:0] LP_RLD = LP_DW - 8'd1;

    localparam logic [1:0] LP_MAN  = 2'b10;
    localparam logic [1:0] LP_AUTO = 2'b01;

    function automatic logic is_oh(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

    function automatic logic [1:0] enc(input logic [2:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        case (1'b1)
            v[2]:    idx = 2'd2;
            v[1]:    idx = 2'd1;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [2:0] dec(input logic [1:0] i);
        return 3'b001 << i;
    endfunction

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [1:0] r_mode;
    logic [1:0] r_col;
    logic [1:0] r_row;
    logic [2:0] r_col_out;
    logic [2:0] r_row_out;
    logic [3:0] r_pos;
    logic       r_busy;
    logic       r_done;
    logic       r_abort;
    logic       r_err;

    logic [1:0] w_mode;
    logic       w_man;
    logic       w_auto;
    logic       w_accept;
    logic [1:0] w_scol;
    logic [1:0] w_srow;
    logic [3:0] w_spos;
    logic       w_last;
    logic [1:0] w_ncol;
    logic [1:0] w_nrow;

    assign w_mode   = {mode_a, mode_b};
    assign w_man    = (w_mode == LP_MAN);
    assign w_auto   = (w_mode == LP_AUTO);
    assign w_accept = w_auto || (w_man && is_oh(col_sel) && is_oh(row_sel));
    assign w_scol   = w_man ? enc(col_sel) : 2'd0;
    assign w_srow   = w_man ? enc(row_sel) : 2'd0;
    assign w_spos   = {2'b00, w_scol} * 4'd3 + {2'b00, w_srow};

    // Scan order: row is the inner index, column the outer one.
    assign w_last   = (r_col == 2'd2) && (r_row == 2'd2);
    assign w_nrow   = (r_row == 2'd2) ? 2'd0 : r_row + 2'd1;
    assign w_ncol   = (r_row == 2'd2) ? r_col + 2'd1 : r_col;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_mode    <= 2'b00;
            r_col     <= 2'd0;
            r_row     <= 2'd0;
            r_col_out <= 3'b000;
            r_row_out <= 3'b000;
            r_pos     <= 4'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_abort   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_accept) begin
                            r_state   <= S_COL;
                            r_mode    <= w_mode;
                            r_col     <= w_scol;
                            r_row     <= w_srow;
                            r_cnt     <= LP_RLD;
                            r_col_out <= dec(w_scol);
                            r_row_out <= 3'b000;
                            r_pos     <= w_spos;
                            r_busy    <= 1'b1;
                            r_err     <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_COL, S_ROW: begin
                    // A mode change beats dwell expiry, so no done on abort.
                    if (w_mode != r_mode) begin
                        r_state   <= S_IDLE;
                        r_abort   <= 1'b1;
                        r_busy    <= 1'b0;
                        r_col_out <= 3'b000;
                        r_row_out <= 3'b000;
                        r_pos     <= 4'd0;
                        r_cnt     <= 8'd0;
                    end else if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else if (r_state == S_COL) begin
                        r_state   <= S_ROW;
                        r_row_out <= dec(r_row);
                        r_cnt     <= LP_RLD;
                    end else if (r_mode == LP_MAN || w_last) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_col_out <= 3'b000;
                        r_row_out <= 3'b000;
                        r_pos     <= 4'd0;
                        r_cnt     <= 8'd0;
                    end else begin
                        r_state   <= S_COL;
                        r_col     <= w_ncol;
                        r_row     <= w_nrow;
                        r_col_out <= dec(w_ncol);
                        r_row_out <= 3'b000;
                        r_pos     <= r_pos + 4'd1;
                        r_cnt     <= LP_RLD;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign col_out = r_col_out;
    assign row_out = r_row_out;
    assign pos_idx = r_pos;
    assign busy    = r_busy;
    assign done    = r_done;
    assign abort   = r_abort;
    assign err     = r_err;

endmodule

// File: tb/tb_coord_sequencer.sv
// Directed bench for coord_sequencer with DWELL=4; expected values are
// hand-derived cycle by cycle from the start cycle.
module tb_coord_sequencer;

    logic       clk;
    logic       rst;
    logic       mode_a;
    logic       mode_b;
    logic [2:0] col_sel;
    logic [2:0] row_sel;
    logic       start;
    logic [2:0] col_out;
    logic [2:0] row_out;
    logic [3:0] pos_idx;
    logic       busy;
    logic       done;
    logic       abort;
    logic       err;

    int n_chk;
    int n_err;

    coord_sequencer #(.DWELL(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .mode_a  (mode_a),
        .mode_b  (mode_b),
        .col_sel (col_sel),
        .row_sel (row_sel),
        .start   (start),
        .col_out (col_out),
        .row_out (row_out),
        .pos_idx (pos_idx),
        .busy    (busy),
        .done    (done),
        .abort   (abort),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Packed as {col_out,row_out,pos_idx,busy,done,abort}.
    task automatic expect_st(input string tag, input logic [2:0] c,
                             input logic [2:0] r, input logic [3:0] p,
                             input logic b, input logic d, input logic a);
        check(tag, {3'b000, col_out, row_out, pos_idx, busy, done, abort},
              {3'b000, c, r, p, b, d, a});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Manual run; checks cycles 1..9 after the start cycle plus the idle after.
    task automatic run_manual(input logic [2:0] c, input logic [2:0] r,
                              input logic [3:0] p);
        mode_a  = 1'b1;
        mode_b  = 1'b0;
        col_sel = c;
        row_sel = r;
        pulse_start();
        for (int k = 1; k <= 8; k++) begin
            if (k <= 4) expect_st("man_col", c, 3'b000, p, 1'b1, 1'b0, 1'b0);
            else        expect_st("man_row", c, r, p, 1'b1, 1'b0, 1'b0);
            tick();
        end
        expect_st("man_done", 3'b000, 3'b000, 4'd0, 1'b0, 1'b1, 1'b0);
        tick();
        expect_st("man_idle", 3'b000, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        rst     = 1'b1;
        mode_a  = 1'b0;
        mode_b  = 1'b0;
        col_sel = 3'b000;
        row_sel = 3'b000;
        start   = 1'b0;
        #22;
        expect_st("reset", 3'b000, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
        check("reset_err", {15'd0, err}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Manual coordinate D/H -> position 1*3+2 = 5
        run_manual(3'b010, 3'b100, 4'd5);

        // Non-one-hot column is rejected, then a valid start clears err
        mode_a  = 1'b1;
        mode_b  = 1'b0;
        col_sel = 3'b011;
        row_sel = 3'b001;
        pulse_start();
        expect_st("bad_sel", 3'b000, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
        check("bad_sel_err", {15'd0, err}, 16'd1);
        run_manual(3'b001, 3'b001, 4'd0);
        check("err_clr", {15'd0, err}, 16'd0);

        // Invalid modes 11 and 00
        mode_a = 1'b1;
        mode_b = 1'b1;
        pulse_start();
        expect_st("mode11", 3'b000, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
        check("mode11_err", {15'd0, err}, 16'd1);
        run_manual(3'b100, 3'b010, 4'd7);
        mode_a = 1'b0;
        mode_b = 1'b0;
        pulse_start();
        check("mode00_err", {15'd0, err}, 16'd1);

        // Auto scan with junk selections and a start pulse mid-run
        mode_a  = 1'b0;
        mode_b  = 1'b1;
        col_sel = 3'b011;
        row_sel = 3'b111;
        pulse_start();
        check("auto_err_clr", {15'd0, err}, 16'd0);
        for (int p = 0; p < 9; p++) begin
            for (int k = 0; k < 8; k++) begin
                logic [2:0] ec;
                logic [2:0] er;
                ec = 3'b001 << (p / 3);
                er = (k < 4) ? 3'b000 : 3'b001 << (p % 3);
                expect_st("auto", ec, er, 4'(p), 1'b1, 1'b0, 1'b0);
                if (p == 1 && k == 2) start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        expect_st("auto_done", 3'b000, 3'b000, 4'd0, 1'b0, 1'b1, 1'b0);
        check("auto_err_keep", {15'd0, err}, 16'd0);
        tick();
        expect_st("auto_idle", 3'b000, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);

        // Auto abort: mode_b dropped at position 3 (cycle 25, D/F column)
        pulse_start();
        repeat (24) tick();
        expect_st("abt_pre", 3'b010, 3'b000, 4'd3, 1'b1, 1'b0, 1'b0);
        mode_b = 1'b0;
        tick();
        expect_st("abt_pulse", 3'b000, 3'b000, 4'd0, 1'b0, 1'b0, 1'b1);
        tick();
        expect_st("abt_after", 3'b000, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
        check("abt_err", {15'd0, err}, 16'd0);

        // Mode change on the final dwell cycle: abort, no done
        mode_a  = 1'b1;
        mode_b  = 1'b0;
        col_sel = 3'b100;
        row_sel = 3'b100;
        pulse_start();
        repeat (7) tick();
        expect_st("last_pre", 3'b100, 3'b100, 4'd8, 1'b1, 1'b0, 1'b0);
        mode_a = 1'b0;
        tick();
        expect_st("last_abt", 3'b000, 3'b000, 4'd0, 1'b0, 1'b0, 1'b1);
        tick();
        expect_st("last_idle", 3'b000, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of ROW
        mode_a  = 1'b1;
        col_sel = 3'b010;
        row_sel = 3'b010;
        pulse_start();
        repeat (5) tick();
        expect_st("rst_pre", 3'b010, 3'b010, 4'd4, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        expect_st("rst_async", 3'b000, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_st("rst_restart", 3'b010, 3'b000, 4'd4, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
